// File: rtl/reg_if_slice.sv
// reg_if_slice: registers every register-interface request and response signal, one cycle each way.
// Build option REG_IF_SLICE_RD_CLEAR_EN: s_reg_rd_data reads 0 except in the read ack cycle.
module reg_if_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH/8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] s_reg_wr_data,
    input  logic [STRB_WIDTH-1:0] s_reg_wr_strb,
    input  logic                  s_reg_wr_en,
    output logic                  s_reg_wr_wait,
    output logic                  s_reg_wr_ack,
    input  logic [ADDR_WIDTH-1:0] s_reg_rd_addr,
    input  logic                  s_reg_rd_en,
    output logic [DATA_WIDTH-1:0] s_reg_rd_data,
    output logic                  s_reg_rd_wait,
    output logic                  s_reg_rd_ack,

    output logic [ADDR_WIDTH-1:0] m_reg_wr_addr,
    output logic [DATA_WIDTH-1:0] m_reg_wr_data,
    output logic [STRB_WIDTH-1:0] m_reg_wr_strb,
    output logic                  m_reg_wr_en,
    input  logic                  m_reg_wr_wait,
    input  logic                  m_reg_wr_ack,
    output logic [ADDR_WIDTH-1:0] m_reg_rd_addr,
    output logic                  m_reg_rd_en,
    input  logic [DATA_WIDTH-1:0] m_reg_rd_data,
    input  logic                  m_reg_rd_wait,
    input  logic                  m_reg_rd_ack
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t wr_state, wr_state_next;
    state_t rd_state, rd_state_next;
    logic   wr_capture, wr_en_next, wr_ack_next, wr_wait_next;
    logic   rd_capture, rd_en_next, rd_ack_next, rd_wait_next;

    // Ack beats a same-cycle abort; wait is forwarded only while the access stays in REQ.
    always_comb begin
        wr_state_next = wr_state;
        wr_capture    = 1'b0;
        unique case (wr_state)
            IDLE: begin
                if (s_reg_wr_en) begin
                    wr_state_next = REQ;
                    wr_capture    = 1'b1;
                end
            end
            REQ: begin
                if (m_reg_wr_ack) begin
                    wr_state_next = DONE;
                end else if (!s_reg_wr_en) begin
                    wr_state_next = IDLE;
                end
            end
            DONE: begin
                if (!s_reg_wr_en) begin
                    wr_state_next = IDLE;
                end
            end
            default: wr_state_next = IDLE;
        endcase
        wr_en_next   = (wr_state_next == REQ);
        wr_ack_next  = (wr_state == REQ) && m_reg_wr_ack;
        wr_wait_next = (wr_state == REQ) && (wr_state_next == REQ) && m_reg_wr_wait;
    end

    always_comb begin
        rd_state_next = rd_state;
        rd_capture    = 1'b0;
        unique case (rd_state)
            IDLE: begin
                if (s_reg_rd_en) begin
                    rd_state_next = REQ;
                    rd_capture    = 1'b1;
                end
            end
            REQ: begin
                if (m_reg_rd_ack) begin
                    rd_state_next = DONE;
                end else if (!s_reg_rd_en) begin
                    rd_state_next = IDLE;
                end
            end
            DONE: begin
                if (!s_reg_rd_en) begin
                    rd_state_next = IDLE;
                end
            end
            default: rd_state_next = IDLE;
        endcase
        rd_en_next   = (rd_state_next == REQ);
        rd_ack_next  = (rd_state == REQ) && m_reg_rd_ack;
        rd_wait_next = (rd_state == REQ) && (rd_state_next == REQ) && m_reg_rd_wait;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state      <= IDLE;
            m_reg_wr_en   <= 1'b0;
            m_reg_wr_addr <= '0;
            m_reg_wr_data <= '0;
            m_reg_wr_strb <= '0;
            s_reg_wr_ack  <= 1'b0;
            s_reg_wr_wait <= 1'b0;
        end else begin
            wr_state      <= wr_state_next;
            m_reg_wr_en   <= wr_en_next;
            s_reg_wr_ack  <= wr_ack_next;
            s_reg_wr_wait <= wr_wait_next;
            if (wr_capture) begin
                m_reg_wr_addr <= s_reg_wr_addr;
                m_reg_wr_data <= s_reg_wr_data;
                m_reg_wr_strb <= s_reg_wr_strb;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state      <= IDLE;
            m_reg_rd_en   <= 1'b0;
            m_reg_rd_addr <= '0;
            s_reg_rd_ack  <= 1'b0;
            s_reg_rd_wait <= 1'b0;
            s_reg_rd_data <= '0;
        end else begin
            rd_state      <= rd_state_next;
            m_reg_rd_en   <= rd_en_next;
            s_reg_rd_ack  <= rd_ack_next;
            s_reg_rd_wait <= rd_wait_next;
            if (rd_capture) begin
                m_reg_rd_addr <= s_reg_rd_addr;
            end
`ifdef REG_IF_SLICE_RD_CLEAR_EN
            s_reg_rd_data <= rd_ack_next ? m_reg_rd_data : '0;
`else
            if (rd_ack_next) begin
                s_reg_rd_data <= m_reg_rd_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_if_slice.sv
// tb_reg_if_slice: randomized bench for reg_if_slice; expected waveforms are derived from
// each access's timeline (request cycle, wait length, ack or abort cycle).
`timescale 1ns/1ps
module tb_reg_if_slice;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_reg_wr_addr, s_reg_wr_data;
    logic [3:0]  s_reg_wr_strb;
    logic        s_reg_wr_en, s_reg_wr_wait, s_reg_wr_ack;
    logic [31:0] s_reg_rd_addr, s_reg_rd_data;
    logic        s_reg_rd_en, s_reg_rd_wait, s_reg_rd_ack;
    logic [31:0] m_reg_wr_addr, m_reg_wr_data;
    logic [3:0]  m_reg_wr_strb;
    logic        m_reg_wr_en, m_reg_wr_wait, m_reg_wr_ack;
    logic [31:0] m_reg_rd_addr, m_reg_rd_data;
    logic        m_reg_rd_en, m_reg_rd_wait, m_reg_rd_ack;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    reg_if_slice #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_reg_wr_addr(s_reg_wr_addr), .s_reg_wr_data(s_reg_wr_data), .s_reg_wr_strb(s_reg_wr_strb),
        .s_reg_wr_en(s_reg_wr_en), .s_reg_wr_wait(s_reg_wr_wait), .s_reg_wr_ack(s_reg_wr_ack),
        .s_reg_rd_addr(s_reg_rd_addr), .s_reg_rd_en(s_reg_rd_en), .s_reg_rd_data(s_reg_rd_data),
        .s_reg_rd_wait(s_reg_rd_wait), .s_reg_rd_ack(s_reg_rd_ack),
        .m_reg_wr_addr(m_reg_wr_addr), .m_reg_wr_data(m_reg_wr_data), .m_reg_wr_strb(m_reg_wr_strb),
        .m_reg_wr_en(m_reg_wr_en), .m_reg_wr_wait(m_reg_wr_wait), .m_reg_wr_ack(m_reg_wr_ack),
        .m_reg_rd_addr(m_reg_rd_addr), .m_reg_rd_en(m_reg_rd_en), .m_reg_rd_data(m_reg_rd_data),
        .m_reg_rd_wait(m_reg_rd_wait), .m_reg_rd_ack(m_reg_rd_ack)
    );

    function automatic logic [137:0] outs();
        return {s_reg_wr_wait, s_reg_wr_ack, s_reg_rd_data, s_reg_rd_wait, s_reg_rd_ack,
                m_reg_wr_addr, m_reg_wr_data, m_reg_wr_strb, m_reg_wr_en, m_reg_rd_addr, m_reg_rd_en};
    endfunction

    // One access on one channel, s_en first high in cycle 0, event cycle e = w + 1.
    // mode 0: ack at e; mode 1: abort at e with a stray ack at e+2; mode 2: ack and abort at e.
    task automatic do_access(input bit rd, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w, input int mode);
        int          e;
        string       nm;
        bit          x_en, x_wait, x_ack, s_en, m_ack, m_wait;
        logic        en_o, wait_o, ack_o;
        logic [31:0] rdat_x;
        e  = w + 1;
        nm = rd ? "rd" : "wr";
        for (int c = 0; c <= e + 3; c++) begin
            @(posedge clk); #1;
            x_en   = (c >= 1) && (c <= e);
            x_wait = (c >= 2) && (c <= e);
            x_ack  = (c == e + 1) && (mode != 1);
            en_o   = rd ? m_reg_rd_en   : m_reg_wr_en;
            wait_o = rd ? s_reg_rd_wait : s_reg_wr_wait;
            ack_o  = rd ? s_reg_rd_ack  : s_reg_wr_ack;
            checks++;
            if (en_o !== x_en) begin
                errors++;
                $display("FAIL %s_m_en c=%0d w=%0d mode=%0d got %b exp %b", nm, c, w, mode, en_o, x_en);
            end
            checks++;
            if (wait_o !== x_wait) begin
                errors++;
                $display("FAIL %s_s_wait c=%0d w=%0d mode=%0d got %b exp %b", nm, c, w, mode, wait_o, x_wait);
            end
            checks++;
            if (ack_o !== x_ack) begin
                errors++;
                $display("FAIL %s_s_ack c=%0d w=%0d mode=%0d got %b exp %b", nm, c, w, mode, ack_o, x_ack);
            end
            if (x_en) begin
                checks++;
                if (rd && m_reg_rd_addr !== addr) begin
                    errors++;
                    $display("FAIL rd_fields c=%0d got %h exp %h", c, m_reg_rd_addr, addr);
                end else if (!rd && {m_reg_wr_addr, m_reg_wr_data, m_reg_wr_strb} !== {addr, data, strb}) begin
                    errors++;
                    $display("FAIL wr_fields c=%0d got %h/%h/%h exp %h/%h/%h", c,
                             m_reg_wr_addr, m_reg_wr_data, m_reg_wr_strb, addr, data, strb);
                end
            end
            if (rd) begin
                if (x_ack) last_rd = data;
`ifdef REG_IF_SLICE_RD_CLEAR_EN
                rdat_x = x_ack ? data : 32'h0;
`else
                rdat_x = last_rd;
`endif
                checks++;
                if (s_reg_rd_data !== rdat_x) begin
                    errors++;
                    $display("FAIL rd_data c=%0d got %h exp %h", c, s_reg_rd_data, rdat_x);
                end
            end
            s_en   = (mode == 0) ? (c <= e + 1) : (c < e);
            m_ack  = (mode == 1) ? (c == e + 2) : (c == e);
            // wait is also raised in IDLE/DONE cycles, where it must not reach upstream
            m_wait = (c <= w) || (c == e + 1);
            if (rd) begin
                s_reg_rd_en   = s_en;
                s_reg_rd_addr = s_en ? addr : $urandom();
                m_reg_rd_ack  = m_ack;
                m_reg_rd_wait = m_wait;
                m_reg_rd_data = m_ack ? data : $urandom();
            end else begin
                s_reg_wr_en   = s_en;
                s_reg_wr_addr = s_en ? addr : $urandom();
                s_reg_wr_data = s_en ? data : $urandom();
                s_reg_wr_strb = s_en ? strb : 4'($urandom());
                m_reg_wr_ack  = m_ack;
                m_reg_wr_wait = m_wait;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_reg_wr_addr = '0; s_reg_wr_data = '0; s_reg_wr_strb = '0; s_reg_wr_en = 1'b0;
        s_reg_rd_addr = '0; s_reg_rd_en = 1'b0;
        m_reg_wr_wait = 1'b0; m_reg_wr_ack = 1'b0;
        m_reg_rd_data = '0; m_reg_rd_wait = 1'b0; m_reg_rd_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", outs());
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL post_reset_idle got %h exp 0", outs());
        end
    endtask

    task automatic test_write_immediate();
        do_access(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    endtask

    task automatic test_read_wait();
        do_access(1'b1, 32'h24, 32'h12345678, 4'h0, 5, 0);
    endtask

    task automatic test_abort();
        do_access(1'b0, 32'h30, 32'hCAFEF00D, 4'h3, 2, 1);
        do_access(1'b1, 32'h34, 32'h0BADF00D, 4'h0, 0, 1);
    endtask

    task automatic test_ack_abort_same();
        do_access(1'b0, 32'h40, 32'h11112222, 4'h5, 1, 2);
        do_access(1'b1, 32'h44, 32'h33334444, 4'h0, 0, 2);
    endtask

    task automatic test_concurrent();
        fork
            do_access(1'b0, 32'h50, 32'h55667788, 4'hC, 3, 0);
            do_access(1'b1, 32'h54, 32'h99AABBCC, 4'h0, 1, 0);
        join
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        s_reg_wr_en = 1'b1; s_reg_wr_addr = $urandom(); s_reg_wr_data = $urandom(); s_reg_wr_strb = 4'hF;
        s_reg_rd_en = 1'b1; s_reg_rd_addr = $urandom(); m_reg_rd_wait = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({m_reg_wr_en, m_reg_rd_en} !== 2'b11) begin
            errors++;
            $display("FAIL mid_reset_setup_en got %b exp 11", {m_reg_wr_en, m_reg_rd_en});
        end
        @(posedge clk); #1;
        checks++;
        if (s_reg_rd_wait !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_setup_wait got %b exp 1", s_reg_rd_wait);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs got %h exp 0", outs());
        end
        s_reg_wr_en = 1'b0; s_reg_rd_en = 1'b0; m_reg_rd_wait = 1'b0;
        last_rd = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reg_wr_ack = 1'b1; m_reg_rd_ack = 1'b1; m_reg_rd_data = $urandom();
        @(posedge clk); #1;
        m_reg_wr_ack = 1'b0; m_reg_rd_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (outs() !== '0) begin
                errors++;
                $display("FAIL post_reset_no_ack i=%0d got %h exp 0", i, outs());
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rd_data_hold();
        logic [31:0] x;
        do_access(1'b1, 32'h60, 32'hA5A5A5A5, 4'h0, 0, 0);
`ifdef REG_IF_SLICE_RD_CLEAR_EN
        x = 32'h0;
`else
        x = 32'hA5A5A5A5;
`endif
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (s_reg_rd_data !== x) begin
                errors++;
                $display("FAIL rd_data_idle i=%0d got %h exp %h", i, s_reg_rd_data, x);
            end
            m_reg_rd_data = $urandom();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit rd;
            int w, mode, w2, mode2;
            rd    = 1'($urandom_range(0, 1));
            w     = int'($urandom_range(0, 6));
            mode  = int'($urandom_range(0, 2));
            w2    = int'($urandom_range(0, 6));
            mode2 = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                fork
                    do_access(1'b0, $urandom(), $urandom(), 4'($urandom()), w, mode);
                    do_access(1'b1, $urandom(), $urandom(), 4'h0, w2, mode2);
                join
            end else begin
                do_access(rd, $urandom(), $urandom(), 4'($urandom()), w, mode);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_immediate();
        test_read_wait();
        test_abort();
        test_ack_abort_same();
        test_concurrent();
        test_reset_mid();
        test_rd_data_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
